muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer that executes MIPS MULT/MULTU/DIV/DIVU and owns the HI/LO result registers. It has no arithmetic array of its own. Every add, subtract and negate is issued to a shared 32-bit ALU instance (ALUFun ADD = 6'b000000, SUB = 6'b000001) through the alu_* ports, one operation per cycle. It sits beside the EX stage; the pipeline stalls on busy.

---
 rtl/muldiv_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// All add/subtract/negate steps are issued to a shared external 32-bit ALU.
module muldiv_seq #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    input  logic [31:0] alu_out
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = $clog2(ITER);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PREP_A = 3'd1;
    localparam logic [2:0] S_PREP_B = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FIX_1  = 3'd4;
    localparam logic [2:0] S_FIX_2  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d;         // multiplicand (abs) / original dividend
    logic [W-1:0]     b_q, b_d;         // original multiplier / divisor (abs)
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;     // product / quotient negative
    logic             negr_q, negr_d;   // remainder negative
    logic             lzero_q, lzero_d; // low word was zero before negation
    logic             dz_q, dz_d;
    logic             busy_q, done_q;

    logic             is_div, is_signed;
    logic [W-1:0]     mul_addend;
    logic             mul_carry;
    logic [W-1:0]     div_s;
    logic             div_borrow, div_ge;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];

    // Carry/borrow recovered from operand and result sign bits of the 32-bit ALU
    assign mul_addend = lo_q[0] ? a_q : '0;
    assign mul_carry  = (hi_q[W-1] & mul_addend[W-1])
                      | ((hi_q[W-1] | mul_addend[W-1]) & ~alu_out[W-1]);
    assign div_s      = {hi_q[W-2:0], lo_q[W-1]};
    assign div_borrow = (~div_s[W-1] & b_q[W-1])
                      | ((~div_s[W-1] | b_q[W-1]) & alu_out[W-1]);
    assign div_ge     = hi_q[W-1] | ~div_borrow;

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign alu_sign = 1'b0;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state, datapath updates and ALU request
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        lzero_d = lzero_q;
        dz_d    = dz_q;
        alu_in1 = '0;
        alu_in2 = '0;
        alu_fun = ALU_ADD;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    a_d    = rs_val;
                    b_d    = rt_val;
                    hi_d   = '0;
                    lo_d   = op[1] ? rs_val : rt_val;
                    cnt_d  = '0;
                    dz_d   = 1'b0;
                    neg_d  = 1'b0;
                    negr_d = 1'b0;
                    if (op[0]) begin
                        state_d = S_PREP_A;
                    end else if (op[1] && (rt_val == '0)) begin
                        state_d = S_DONE;
                        hi_d    = rs_val;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_PREP_A: begin
                alu_fun = ALU_SUB;
                alu_in2 = a_q;
                neg_d   = a_q[W-1];
                negr_d  = a_q[W-1];
                if (a_q[W-1]) begin
                    if (is_div) lo_d = alu_out;
                    else        a_d  = alu_out;
                end
                state_d = S_PREP_B;
            end
            S_PREP_B: begin
                alu_fun = ALU_SUB;
                alu_in2 = b_q;
                neg_d   = neg_q ^ b_q[W-1];
                if (b_q[W-1]) begin
                    if (is_div) b_d  = alu_out;
                    else        lo_d = alu_out;
                end
                if (is_div && (b_q == '0)) begin
                    state_d = S_DONE;
                    hi_d    = a_q;
                    lo_d    = '1;
                    dz_d    = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div) begin
                    alu_fun = ALU_SUB;
                    alu_in1 = div_s;
                    alu_in2 = b_q;
                    if (div_ge) begin
                        hi_d = alu_out;
                        lo_d = {lo_q[W-2:0], 1'b1};
                    end else begin
                        hi_d = div_s;
                        lo_d = {lo_q[W-2:0], 1'b0};
                    end
                end else begin
                    alu_fun = ALU_ADD;
                    alu_in1 = hi_q;
                    alu_in2 = mul_addend;
                    hi_d    = {mul_carry, alu_out[W-1:1]};
                    lo_d    = {alu_out[0], lo_q[W-1:1]};
                end
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = is_signed ? S_FIX_1 : S_DONE;
                end
            end
            S_FIX_1: begin
                alu_fun = ALU_SUB;
                alu_in2 = lo_q;
                lzero_d = (lo_q == '0);
                if (neg_q) lo_d = alu_out;
                state_d = S_FIX_2;
            end
            S_FIX_2: begin
                alu_fun = ALU_SUB;
                alu_in2 = hi_q;
                if (is_div) begin
                    if (negr_q) hi_d = alu_out;
                end else if (neg_q) begin
                    hi_d = lzero_q ? alu_out : ~hi_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            lzero_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            lzero_q <= lzero_d;
            dz_q    <= dz_d;
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q  <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, corner sequences, random vs. model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    logic [31:0] alu_in1, alu_in2;
    logic [5:0]  alu_fun;
    logic        alu_sign;
    logic [31:0] alu_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Shared ALU stand-in: ADD / SUB only
    assign alu_out = (alu_fun == 6'b000001) ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);

    muldiv_seq #(.ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_fun(alu_fun), .alu_sign(alu_sign),
        .alu_out(alu_out)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        string       name;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic edz, output int elat);
        longint unsigned up;
        longint          sp, sq, sr;
        edz  = 1'b0;
        elat = o[0] ? 37 : 33;
        eh   = '0;
        el   = '0;
        case (o)
            2'b00: begin
                up = {32'h0, a} * {32'h0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            2'b01: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                eh = sp[63:32];
                el = sp[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    eh   = a;
                    el   = 32'hFFFFFFFF;
                    edz  = 1'b1;
                    elat = o[0] ? 3 : 1;
                end else if (o == 2'b10) begin
                    el = a / b;
                    eh = a % b;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    el = sq[31:0];
                    eh = sr[31:0];
                end
            end
        endcase
    endtask

    // Launch one op from IDLE (called at a negedge) and check result, latency and busy shape.
    // inject > 0 pulses start/hi_we/lo_we with junk at that cycle while busy.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input int elat, input string name, input int inject);
        int cyc      = 0;
        bit got      = 1'b0;
        bit busy_bad = 1'b0;
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        while (!got && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1'b1;
                if (busy) busy_bad = 1'b1;
            end else if (!busy) begin
                busy_bad = 1'b1;
            end
            if (cyc == 1 && !edz) check({name, " div_zero cleared"}, 32'(div_zero), 32'h0);
            start = 1'b0;
            hi_we = 1'b0;
            lo_we = 1'b0;
            if (cyc == inject) begin
                start  = 1'b1;
                op     = ~o;
                rs_val = $urandom;
                rt_val = $urandom;
                hi_we  = 1'b1;
                lo_we  = 1'b1;
                wdata  = 32'hDEADBEEF;
            end
        end
        check({name, " latency"}, 32'(cyc), 32'(elat));
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
        check({name, " div_zero"}, 32'(div_zero), 32'(edz));
        check({name, " busy shape"}, 32'(busy_bad), 32'h0);
        @(negedge clk);
        check({name, " done one-shot"}, 32'(done), 32'h0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] eh, el, a, b;
        logic        edz;
        int          elat, cyc;
        logic [1:0]  o;

        tbl[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, "MULTU max"};
        tbl[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 37, "MULT -3*7"};
        tbl[2] = '{2'b01, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0, 37, "MULT 0*-5"};
        tbl[3] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, "DIVU 100/7"};
        tbl[4] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 37, "DIV -7/2"};
        tbl[5] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 37, "DIV min/-1"};
        tbl[6] = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1,  "DIVU by 0"};
        tbl[7] = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 3,  "DIV by 0"};
        tbl[8] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 37, "MULT min*min"};
        tbl[9] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 37, "DIV 7/-2"};

        reset = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #1;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset div_zero", 32'(div_zero), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check("idle alu_in1", alu_in1, 32'h0);
        check("idle alu_in2", alu_in2, 32'h0);
        check("idle alu_fun", 32'(alu_fun), 32'h0);
        check("alu_sign", 32'(alu_sign), 32'h0);

        // MTHI / MTLO in IDLE
        hi_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        check("MTHI hi", hi, 32'hA5A5A5A5);
        lo_we = 1'b1; wdata = 32'h5A5A5A5A;
        @(negedge clk);
        lo_we = 1'b0;
        check("MTLO lo", lo, 32'h5A5A5A5A);
        check("MTLO keeps hi", hi, 32'hA5A5A5A5);

        foreach (tbl[i])
            do_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo, tbl[i].dz,
                  tbl[i].lat, tbl[i].name, 0);

        // start and lo_we together: write dropped, dividend loaded into lo
        op = 2'b10; rs_val = 32'd100; rt_val = 32'd7;
        start = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        check("start+lo_we lo", lo, 32'd100);
        cyc = 1;
        while (!done && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        check("start+lo_we latency", 32'(cyc), 32'd33);
        check("start+lo_we quotient", lo, 32'd14);
        @(negedge clk);

        // Junk start / hi_we / lo_we mid-RUN must be ignored
        model(2'b00, 32'h12345678, 32'h9ABCDEF0, eh, el, edz, elat);
        do_op(2'b00, 32'h12345678, 32'h9ABCDEF0, eh, el, edz, elat, "MULTU inject", 10);
        model(2'b11, 32'hF0000001, 32'h00000013, eh, el, edz, elat);
        do_op(2'b11, 32'hF0000001, 32'h00000013, eh, el, edz, elat, "DIV inject", 20);

        // Reset mid-DIVU aborts immediately
        op = 2'b10; rs_val = 32'h00ABCDEF; rt_val = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, "MULTU 6*7 after abort", 0);

        // Random ops against the arithmetic model
        for (int k = 0; k < 150; k++) begin
            o = 2'($urandom_range(0, 3));
            a = rnd_val();
            b = rnd_val();
            model(o, a, b, eh, el, edz, elat);
            do_op(o, a, b, eh, el, edz, elat, $sformatf("rand%0d op%0d", k, o), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
